icache_ctrl: RTL

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl_pkg.sv | 13 +
 rtl/icache_array.sv | 56 +++++
 rtl/icache_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache: fill FSM encoding
// and default cache geometry.
package icache_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } ic_state_t;

    localparam int DEF_LINES = 8;
    localparam int DEF_WORDS = 4;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the instruction cache: one fill-side write port
// and one combinational lookup port selected by index and word offset.
import icache_ctrl_pkg::*;

module icache_array #(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS,
    parameter int TAG_W = 30 - $clog2(DEF_LINES) - $clog2(DEF_WORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(LINES)-1:0]   rd_idx,
    input  logic [$clog2(WORDS)-1:0]   rd_off,
    output logic                       rd_valid,
    output logic [TAG_W-1:0]           rd_tag,
    output logic [31:0]                rd_data,
    input  logic                       wr_en,
    input  logic [$clog2(LINES)-1:0]   wr_idx,
    input  logic [$clog2(WORDS)-1:0]   wr_off,
    input  logic [31:0]                wr_data,
    input  logic                       tag_we,
    input  logic [TAG_W-1:0]           wr_tag,
    input  logic                       set_valid,
    input  logic                       inv_all
);

    logic [LINES-1:0] valid_r;
    logic [TAG_W-1:0] tag_mem [LINES];
    logic [31:0]      data_mem [LINES*WORDS];

    // Valid bits: invalidate-all wins over a line completing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
        end else if (inv_all) begin
            valid_r <= '0;
        end else if (set_valid) begin
            valid_r[wr_idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_idx, wr_off}] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[{rd_idx, rd_off}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with a blocking line fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
import icache_ctrl_pkg::*;

module icache_ctrl #(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [31:0] pc,
    input  logic        inv,
    output logic [31:0] instr,
    output logic        ic_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_W   = 30 - OFF_W - IDX_W;
    localparam int LSB_IDX = OFF_W + 2;
    localparam int LSB_TAG = OFF_W + IDX_W + 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);
    localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);

    ic_state_t              state_r;
    logic [31-LSB_IDX:0]    line_r;
    logic [OFF_W-1:0]       beat_r;
    logic                   inv_seen_r;
    logic                   mem_req_r;
    logic [31:0]            mem_addr_r;

    logic                   rd_valid_s;
    logic [TAG_W-1:0]       rd_tag_s;
    logic [31:0]            rd_data_s;
    logic                   hit_s;
    logic                   miss_s;
    logic                   fill_ack_s;
    logic                   fill_last_s;
    logic                   set_valid_s;
    logic                   pc_unused_s;

    assign pc_unused_s = ^pc[1:0];
    assign fill_ack_s  = (state_r == FILL) && mem_ack;
    assign fill_last_s = fill_ack_s && (beat_r == LAST_BEAT);
    // A line whose fill saw an invalidate is written but never marked valid.
    assign set_valid_s = fill_last_s && !inv_seen_r && !inv;

    // Lookup is combinational so a hit returns its word with no bubble.
    always_comb begin
        hit_s  = 1'b0;
        miss_s = 1'b0;
        if ((state_r == IDLE) && fetch_en) begin
            hit_s  = rd_valid_s && (rd_tag_s == pc[31:LSB_TAG]);
            miss_s = !hit_s;
        end else begin
            hit_s  = 1'b0;
            miss_s = 1'b0;
        end
    end

    // Pipeline-facing outputs follow the lookup in the same cycle.
    always_comb begin
        instr    = rd_data_s;
        ic_stall = miss_s || (state_r != IDLE);
    end

    // Fill FSM: latch the missing line, then walk its words until the last ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            line_r     <= '0;
            beat_r     <= '0;
            inv_seen_r <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss_s) begin
                        state_r    <= FILL;
                        line_r     <= pc[31:LSB_IDX];
                        beat_r     <= '0;
                        inv_seen_r <= 1'b0;
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= {pc[31:LSB_IDX], {LSB_IDX{1'b0}}};
                    end
                end
                FILL: begin
                    if (inv) begin
                        inv_seen_r <= 1'b1;
                    end
                    if (mem_ack) begin
                        beat_r <= beat_r + BEAT_ONE;
                        if (beat_r == LAST_BEAT) begin
                            state_r    <= IDLE;
                            mem_req_r  <= 1'b0;
                            mem_addr_r <= 32'd0;
                        end else begin
                            mem_addr_r <= mem_addr_r + 32'd4;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pc[LSB_TAG-1:LSB_IDX]),
        .rd_off    (pc[LSB_IDX-1:2]),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_data   (rd_data_s),
        .wr_en     (fill_ack_s),
        .wr_idx    (line_r[IDX_W-1:0]),
        .wr_off    (beat_r),
        .wr_data   (mem_data),
        .tag_we    (fill_last_s),
        .wr_tag    (line_r[31-LSB_IDX:IDX_W]),
        .set_valid (set_valid_s),
        .inv_all   (inv)
    );

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Performance counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (hit_s) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (miss_s) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`endif

endmodule
